cdc_hs_src_ctrl: RTL and testbench
==================================

# cdc_hs_src_ctrl

Source-side controller for a four-phase req/ack handshake that moves a multi-bit word from the `clk_i` domain into an unrelated destination domain. It accepts a word through a valid/ready port, holds it stable on `data_o`, and sequences `req_o`. It watches the destination's asynchronous `ack_i` through a 2-FF synchronizer and flags transfers whose acknowledge is overdue. It sits on the source side of every multi-bit CDC link where Gray coding is not applicable.

## Interface
- DATA_WIDTH, 8: width of transferred word.
- TIMEOUT_CYCLES, 64: cycles a handshake phase may wait for `ack_sync` before `timeout_o` sets; 0 disables the timeout.
- CNT_WIDTH, 16: width of completed-transfer counter.
- clk_i  in  1  source-domain clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  1  word available on data_i.
- ready_o  out  1  controller idle, will accept.
- data_i  in  DATA_WIDTH  word to transfer.
- data_o  out  DATA_WIDTH  held word, to destination domain.
- req_o  out  1  handshake request, registered, to destination domain.
- ack_i  in  1  destination acknowledge, asynchronous to clk_i.
- busy_o  out  1  handshake in progress (state != IDLE).
- timeout_o  out  1  sticky overdue-acknowledge flag.
- clr_timeout_i  in  1  clears timeout_o.
- xfer_cnt_o  out  CNT_WIDTH  completed transfers, wraps modulo 2^CNT_WIDTH.

## Operation
- FSM states are IDLE, REQ and RELEASE. Reset state is IDLE.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o: data_q<=data_i, go to REQ.
- REQ:
  - req_o=1.
  - When ack_sync==1, go to RELEASE.
- RELEASE:
  - req_o=0.
  - When ack_sync==0, go to IDLE and increment xfer_cnt.
- ack_sync is ack_i passed through one synchronizer_2ff (DATA_WIDTH=1, reset 0). ack_i is never used unsynchronized.
- req_o is a flop driven from next-state (REQ) and carries no combinational path.
- data_o = data_q. It changes only on accept, so it is stable whenever req_o or ack_sync is high.
- Timeout counter:
  - Cleared on every state entry. Counts in REQ and RELEASE and saturates.
  - Reaching TIMEOUT_CYCLES sets timeout_o.
  - The FSM never aborts on timeout; it keeps waiting, because the protocol cannot be safely unwound.
- clr_timeout_i clears timeout_o. A same-cycle set and clear leaves timeout_o=1 (set wins).
- valid_i while busy is ignored and data_i is not sampled. The upstream producer holds its word until ready_o.
- Reset values: ready_o=1, req_o=0, busy_o=0, data_o=0, timeout_o=0, xfer_cnt_o=0, synchronizer flops=0.
- Reset mid-handshake returns to IDLE with req_o=0 immediately (asynchronous). The destination controller must be reset in the same system reset; that is a system requirement.

## Timing
- Accept at edge E0 gives req_o=1 and busy_o=1 after E0.
- ack_i rising before edge Ea gives ack_sync=1 after Ea+1, and the FSM leaves REQ at edge Ea+2.
- Loopback (ack_i=req_o):
  - req_o falls after E3.
  - IDLE after E6.
  - Next accept at E7.
  - Sustained throughput is one word per 7 cycles.
- xfer_cnt_o increments on the edge entering IDLE.
- The timeout counter uses $clog2(TIMEOUT_CYCLES+1) bits. timeout_o rises TIMEOUT_CYCLES cycles after state entry if ack_sync is still unchanged.

## Structure
- Shared package cdc_pkg holds typedef enum logic [1:0] hs_state_e {HS_IDLE, HS_REQ, HS_RELEASE}. The destination-side controller reuses it.
- One sub-module: synchronizer_2ff instance u_ack_sync for ack_i.
- The FSM, data register, timeout counter and transfer counter live in this module.

## Test plan
- Reset then idle:
  - Response: ready_o=1, req_o=0, data_o=0, xfer_cnt_o=0, timeout_o=0.
- Loopback ack_i=req_o, back-to-back valid_i with data_i=0xA5, 0x3C:
  - Accepts at E0 and E7.
  - data_o=0xA5 from E0 to E7, then 0x3C.
  - xfer_cnt_o=2 after E13.
- Destination delays ack_i by 20 cycles, TIMEOUT_CYCLES=8:
  - timeout_o=1 after 8 cycles in REQ.
  - Transfer still completes and xfer_cnt_o=1.
  - timeout_o stays 1 until clr_timeout_i.
- clr_timeout_i asserted the same cycle the timeout fires:
  - timeout_o=1 after the edge.
  - Clearing one cycle later gives 0.
- valid_i with data_i=0xFF asserted while busy:
  - Ignored; data_o keeps its prior word.
  - The word is accepted only once ready_o=1.
- rst_ni low during RELEASE:
  - Asynchronously req_o=0, state IDLE, xfer_cnt_o=0.
  - After release, a loopback transfer of 0x5A completes normally.

Source files
------------

// File: rtl/cdc_pkg.sv
// ---------------------------------------------------------------------------
// cdc_pkg
// Shared types for the four-phase req/ack CDC handshake controllers.
// The source-side and destination-side controllers both use hs_state_e,
// so the two ends of a link describe their phases with the same names.
// ---------------------------------------------------------------------------
package cdc_pkg;

    typedef enum logic [1:0] {
        HS_IDLE    = 2'd0,
        HS_REQ     = 2'd1,
        HS_RELEASE = 2'd2
    } hs_state_e;

endpackage

// File: rtl/synchronizer_2ff.sv
// ---------------------------------------------------------------------------
// synchronizer_2ff
// Two-flop synchronizer that brings an asynchronous level into clk_i.
// Each bit is synchronized independently, so only use DATA_WIDTH > 1 for
// bits that do not need to be seen coherently.
//
// Ports:
//   clk_i   destination clock
//   rst_ni  asynchronous active-low reset, both flops clear to 0
//   d_i     asynchronous input level
//   q_o     synchronized level, two clk_i edges after d_i settles
// ---------------------------------------------------------------------------
module synchronizer_2ff #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] sync_p0;
    logic [DATA_WIDTH-1:0] sync_p1;

    // p0 may go metastable; p1 gives it a full cycle to resolve
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= d_i;
            sync_p1 <= sync_p0;
        end
    end

    assign q_o = sync_p1;

endmodule

// File: rtl/cdc_hs_src_ctrl.sv
// ---------------------------------------------------------------------------
// cdc_hs_src_ctrl
// Source side of a four-phase req/ack handshake carrying a DATA_WIDTH word
// into an unrelated clock domain. A word accepted on valid_i/ready_o is held
// on data_o for the whole handshake; req_o is raised, the FSM waits for the
// synchronized acknowledge to rise, drops req_o, then waits for it to fall.
// A phase that waits TIMEOUT_CYCLES without progress sets a sticky flag, but
// the FSM keeps waiting: a half-finished four-phase handshake cannot be
// unwound safely from one side.
//
// Ports:
//   clk_i          source-domain clock
//   rst_ni         asynchronous active-low reset
//   valid_i        word available on data_i
//   ready_o        idle, a word will be accepted
//   data_i         word to transfer
//   data_o         held word, stable while req_o or the acknowledge is high
//   req_o          registered request to the destination domain
//   ack_i          destination acknowledge, asynchronous to clk_i
//   busy_o         handshake in progress
//   timeout_o      sticky overdue-acknowledge flag
//   clr_timeout_i  clears timeout_o (a same-cycle set wins)
//   xfer_cnt_o     completed transfers, wraps
// ---------------------------------------------------------------------------
module cdc_hs_src_ctrl
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  req_o,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  timeout_o,
    input  logic                  clr_timeout_i,
    output logic [CNT_WIDTH-1:0]  xfer_cnt_o
);

    // A zero TIMEOUT_CYCLES disables the timeout; keep the counter one bit
    // wide so the declarations stay legal.
    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    hs_state_e              state_q;
    hs_state_e              state_d;
    logic                   accept;
    logic                   xfer_done;
    logic                   ack_sync;
    logic                   req_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [TMO_W-1:0]       tmo_cnt_q;
    logic [TMO_W-1:0]       tmo_cnt_d;
    logic                   tmo_set;
    logic                   tmo_q;
    logic [CNT_WIDTH-1:0]   xfer_cnt_q;

    synchronizer_2ff #(
        .DATA_WIDTH (1)
    ) u_ack_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (ack_i),
        .q_o    (ack_sync)
    );

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        xfer_done = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (valid_i) begin
                    state_d = HS_REQ;
                    accept  = 1'b1;
                end
            end
            HS_REQ: begin
                if (ack_sync) begin
                    state_d = HS_RELEASE;
                end
            end
            HS_RELEASE: begin
                if (!ack_sync) begin
                    state_d   = HS_IDLE;
                    xfer_done = 1'b1;
                end
            end
            default: begin
                state_d = HS_IDLE;
            end
        endcase
    end

    // Phase timer: restarts on every state change, counts only while a
    // handshake phase is waiting, and sticks at TMO_MAX.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if ((state_q != HS_IDLE) && (tmo_cnt_q != TMO_MAX)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    // Fires only on the cycle the limit is first reached, so a clear issued
    // later while the counter sits saturated is not immediately undone.
    assign tmo_set = (TIMEOUT_CYCLES != 0) && (tmo_cnt_d == TMO_MAX) &&
                     (tmo_cnt_q != TMO_MAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= HS_IDLE;
            req_q      <= 1'b0;
            data_q     <= '0;
            tmo_cnt_q  <= '0;
            tmo_q      <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            // Registered from next state so req_o has no combinational path
            req_q     <= (state_d == HS_REQ);
            tmo_cnt_q <= tmo_cnt_d;
            if (accept) begin
                data_q <= data_i;
            end
            if (tmo_set) begin
                tmo_q <= 1'b1;
            end else if (clr_timeout_i) begin
                tmo_q <= 1'b0;
            end
            if (xfer_done) begin
                xfer_cnt_q <= xfer_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign ready_o    = (state_q == HS_IDLE);
    assign busy_o     = (state_q != HS_IDLE);
    assign req_o      = req_q;
    assign data_o     = data_q;
    assign timeout_o  = tmo_q;
    assign xfer_cnt_o = xfer_cnt_q;

endmodule

// File: tb/tb_cdc_hs_src_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cdc_hs_src_ctrl
// Bench for the source-side handshake controller. A destination stand-in
// returns ack_i as req_o delayed by a programmable number of cycles
// (0 = loopback). A transaction-level model predicts every output each cycle;
// directed scenarios add literal expectations, then a randomized run follows.
// ---------------------------------------------------------------------------
module tb_cdc_hs_src_ctrl;

    localparam int DW = 8;
    localparam int TO = 8;
    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [DW-1:0] data_i = '0;
    logic [DW-1:0] data_o;
    logic          req_o;
    logic          ack_i = 1'b0;
    logic          busy_o;
    logic          timeout_o;
    logic          clr_timeout_i = 1'b0;
    logic [CW-1:0] xfer_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    cdc_hs_src_ctrl #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_i        (data_i),
        .data_o        (data_o),
        .req_o         (req_o),
        .ack_i         (ack_i),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o),
        .clr_timeout_i (clr_timeout_i),
        .xfer_cnt_o    (xfer_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Destination stand-in: ack_i follows req_o delayed by ack_dly cycles.
    int          ack_dly = 0;
    logic [31:0] req_hist = '0;
    initial begin
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) begin
                req_hist = '0;
                ack_i    = 1'b0;
            end else begin
                #1;
                req_hist = {req_hist[30:0], req_o};
                ack_i    = req_hist[ack_dly];
            end
        end
    end

    // Transaction-level model. phase: 0 idle, 1 waiting for ack high,
    // 2 waiting for ack low. ack is seen two edges late (two-flop sync).
    int         m_phase = 0;
    logic [7:0] m_data = '0;
    int         m_cnt = 0;
    bit         m_tmo = 1'b0;
    int         m_timer = 0;
    bit         m_ack_d1 = 1'b0;
    bit         m_ack_d2 = 1'b0;
    initial begin
        int  prev;
        bit  seen;
        bit  fire;
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) begin
                m_phase = 0; m_data = '0; m_cnt = 0; m_tmo = 1'b0;
                m_timer = 0; m_ack_d1 = 1'b0; m_ack_d2 = 1'b0;
            end else begin
                seen     = m_ack_d2;
                m_ack_d2 = m_ack_d1;
                m_ack_d1 = ack_i;
                prev     = m_phase;
                fire     = 1'b0;
                if (m_phase == 0) begin
                    if (valid_i) begin
                        m_data  = data_i;
                        m_phase = 1;
                    end
                end else if ((m_phase == 1) == seen) begin
                    // waited-for ack level observed: advance phase
                    if (m_phase == 1) begin
                        m_phase = 2;
                    end else begin
                        m_phase = 0;
                        m_cnt   = (m_cnt + 1) % (1 << CW);
                    end
                end
                if (m_phase != prev) begin
                    m_timer = 0;
                end else if (m_phase != 0 && m_timer < TO) begin
                    m_timer++;
                    fire = (m_timer == TO);
                end
                if (fire) m_tmo = 1'b1;
                else if (clr_timeout_i) m_tmo = 1'b0;
            end
        end
    end

    bit chk_en = 1'b0;
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && chk_en) begin
                check("m_ready", ready_o, m_phase == 0);
                check("m_req", req_o, m_phase == 1);
                check("m_busy", busy_o, m_phase != 0);
                check("m_data", data_o, m_data);
                check("m_timeout", timeout_o, m_tmo);
                check("m_xfer_cnt", xfer_cnt_o, m_cnt);
            end
        end
    end

    task automatic do_reset();
        rst_ni = 1'b0; valid_i = 1'b0; clr_timeout_i = 1'b0; data_i = '0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic wait_ready(input int max_cyc, input string name);
        int k = 0;
        while (!ready_o && k < max_cyc) begin
            @(negedge clk_i);
            k++;
        end
        check({name, "_bound"}, ready_o, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_ready", ready_o, 1);
        check("rst_req", req_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_data", data_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_cnt", xfer_cnt_o, 0);
        rst_ni = 1'b1;
        chk_en = 1'b1;
        @(negedge clk_i);
        check("idle_ready", ready_o, 1);

        // Loopback, back-to-back words A5 then 3C
        ack_dly = 0;
        valid_i = 1'b1; data_i = 8'hA5;
        @(negedge clk_i);                       // after E0
        check("lb_req_e0", req_o, 1);
        check("lb_busy_e0", busy_o, 1);
        check("lb_data_e0", data_o, 8'hA5);
        data_i = 8'h3C;
        repeat (3) @(negedge clk_i);            // after E3
        check("lb_req_e3", req_o, 0);
        check("lb_data_e3", data_o, 8'hA5);
        repeat (3) @(negedge clk_i);            // after E6
        check("lb_ready_e6", ready_o, 1);
        check("lb_cnt_e6", xfer_cnt_o, 1);
        check("lb_data_e6", data_o, 8'hA5);
        @(negedge clk_i);                       // after E7
        check("lb_data_e7", data_o, 8'h3C);
        check("lb_req_e7", req_o, 1);
        valid_i = 1'b0;
        repeat (5) @(negedge clk_i);            // after E12
        check("lb_cnt_e12", xfer_cnt_o, 1);
        @(negedge clk_i);                       // after E13
        check("lb_cnt_e13", xfer_cnt_o, 2);
        check("lb_ready_e13", ready_o, 1);

        // Slow destination: timeout sets, transfer still completes
        do_reset();
        ack_dly = 20;
        valid_i = 1'b1; data_i = 8'h11;
        @(negedge clk_i);                       // after E0
        valid_i = 1'b0;
        repeat (7) @(negedge clk_i);            // after E7
        check("to_e7", timeout_o, 0);
        @(negedge clk_i);                       // after E8
        check("to_e8", timeout_o, 1);
        check("to_req_e8", req_o, 1);
        wait_ready(100, "to_done");
        check("to_cnt", xfer_cnt_o, 1);
        check("to_sticky", timeout_o, 1);
        clr_timeout_i = 1'b1;
        @(negedge clk_i);
        check("to_cleared", timeout_o, 0);
        clr_timeout_i = 1'b0;

        // Clear in the same cycle the timeout fires: set wins
        do_reset();
        ack_dly = 20;
        valid_i = 1'b1; data_i = 8'h22;
        @(negedge clk_i);                       // after E0
        valid_i = 1'b0;
        repeat (7) @(negedge clk_i);            // after E7
        clr_timeout_i = 1'b1;
        @(negedge clk_i);                       // after E8
        check("clr_same_e8", timeout_o, 1);
        @(negedge clk_i);                       // after E9
        check("clr_next_e9", timeout_o, 0);
        clr_timeout_i = 1'b0;
        wait_ready(100, "clr_done");

        // valid_i while busy is ignored
        do_reset();
        ack_dly = 0;
        valid_i = 1'b1; data_i = 8'h42;
        @(negedge clk_i);                       // after E0
        data_i = 8'hFF;
        repeat (3) @(negedge clk_i);            // after E3
        check("busy_data_e3", data_o, 8'h42);
        check("busy_busy_e3", busy_o, 1);
        repeat (3) @(negedge clk_i);            // after E6
        check("busy_data_e6", data_o, 8'h42);
        @(negedge clk_i);                       // after E7
        check("busy_accept_e7", data_o, 8'hFF);
        valid_i = 1'b0;
        wait_ready(20, "busy_done");

        // Asynchronous reset during RELEASE
        do_reset();
        ack_dly = 0;
        valid_i = 1'b1; data_i = 8'h33;
        @(negedge clk_i);
        valid_i = 1'b0;
        wait_ready(20, "rr_first");
        check("rr_cnt_pre", xfer_cnt_o, 1);
        valid_i = 1'b1; data_i = 8'h44;
        @(negedge clk_i);                       // after E0
        valid_i = 1'b0;
        repeat (4) @(negedge clk_i);            // after E4, in RELEASE
        check("rr_rel_req", req_o, 0);
        check("rr_rel_busy", busy_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rr_async_req", req_o, 0);
        check("rr_async_busy", busy_o, 0);
        check("rr_async_ready", ready_o, 1);
        check("rr_async_cnt", xfer_cnt_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        valid_i = 1'b1; data_i = 8'h5A;
        @(negedge clk_i);                       // after E0
        check("rr_data_e0", data_o, 8'h5A);
        check("rr_req_e0", req_o, 1);
        valid_i = 1'b0;
        repeat (6) @(negedge clk_i);            // after E6
        check("rr_cnt_e6", xfer_cnt_o, 1);
        check("rr_ready_e6", ready_o, 1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            valid_i       = ($urandom_range(0, 2) != 0);
            data_i        = 8'($urandom);
            clr_timeout_i = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) ack_dly = int'($urandom_range(0, 12));
        end
        valid_i = 1'b0;
        clr_timeout_i = 1'b0;
        ack_dly = 0;
        wait_ready(100, "rand_drain");
        @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
